// File: rtl/even_parity_serializer.sv
// even_parity_serializer
//
// Framed serial transmitter with even parity. A parallel word is taken over a
// valid/ready handshake and sent as: start bit (0), DATA_W data bits LSB
// first, parity bit, stop bit (1). Every bit is held for BAUD_DIV clocks.
//
// Parameters:
//   DATA_W   - data word width (>= 1)
//   BAUD_DIV - clocks per serial bit (>= 1)
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   in_data  - word to transmit, sampled only at the handshake edge
//   in_valid - in_data is valid
//   in_ready - block can accept a word (IDLE only, low while rst is high)
//   tx       - serial line, idles high
//   busy     - a frame is in flight (any state but IDLE)
//   done     - one-cycle pulse in the last clock of the stop bit
//   inj_err  - only with PARITY_ERR_INJ_EN: invert the parity of the frame
//              accepted on this edge
//
// Optional feature macro: PARITY_ERR_INJ_EN (adds inj_err).
//
// Handshake: a word transfers on the rising edge where in_valid && in_ready.
// in_ready is high only in IDLE, so a word offered while busy is neither
// accepted nor queued; the producer must keep in_valid high until it is.
module even_parity_serializer #(
  parameter int DATA_W   = 8,
  parameter int BAUD_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
`ifdef PARITY_ERR_INJ_EN
  ,
  input  logic              inj_err
`endif
);

  localparam int BCW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int DCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [BCW-1:0]    baud_cnt;
  logic [DCW-1:0]    bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              parity_bit;
  logic              inj;
  logic              accept;
  logic              bit_end;
  logic              last_bit;

`ifdef PARITY_ERR_INJ_EN
  assign inj = inj_err;
`else
  assign inj = 1'b0;
`endif

  assign accept   = in_valid && in_ready;
  assign bit_end  = (baud_cnt == BCW'(BAUD_DIV - 1));
  assign last_bit = (bit_cnt == DCW'(DATA_W - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and outputs
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    tx       = 1'b1;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = !rst;
        if (in_valid && !rst) state_nx = START;
      end
      START: begin
        tx = 1'b0;
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        tx = shift_reg[0];
        if (bit_end && last_bit) state_nx = PARITY;
      end
      PARITY: begin
        tx = parity_bit;
        if (bit_end) state_nx = STOP;
      end
      STOP: begin
        tx   = 1'b1;
        done = bit_end;
        if (bit_end) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset wins immediately on the outputs so a frame cut short by reset
    // never shows a done pulse or a dangling low on the line.
    if (rst) begin
      tx       = 1'b1;
      busy     = 1'b0;
      done     = 1'b0;
      in_ready = 1'b0;
    end
  end

  // Datapath: word/parity capture, baud and bit counters, shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else if (accept) begin
      shift_reg  <= in_data;
      parity_bit <= (^in_data) ^ inj;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
    end else if (state != IDLE) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (state == DATA) begin
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_even_parity_serializer.sv
// Bench for even_parity_serializer: a DATA_W=8/BAUD_DIV=4 instance for the
// main frame tests and a DATA_W=3/BAUD_DIV=1 instance for the small corner.
module tb_even_parity_serializer;

  localparam int DW = 8;
  localparam int BD = 4;
  localparam int FB = DW + 3;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          tx;
  logic          busy;
  logic          done;

  logic [2:0]    in_data3;
  logic          in_valid3;
  logic          in_ready3;
  logic          tx3;
  logic          busy3;
  logic          done3;

`ifdef PARITY_ERR_INJ_EN
  logic          inj_err;
  logic          inj_err3;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  even_parity_serializer #(.DATA_W(DW), .BAUD_DIV(BD)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
`ifdef PARITY_ERR_INJ_EN
    ,
    .inj_err  (inj_err)
`endif
  );

  even_parity_serializer #(.DATA_W(3), .BAUD_DIV(1)) u_dut3 (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data3),
    .in_valid (in_valid3),
    .in_ready (in_ready3),
    .tx       (tx3),
    .busy     (busy3),
    .done     (done3)
`ifdef PARITY_ERR_INJ_EN
    ,
    .inj_err  (inj_err3)
`endif
  );

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Send one word on the 8-bit instance and check {tx,done,busy,in_ready}
  // every cycle of the frame plus the idle cycle after it. Starts and ends on
  // a negedge where the block is idle.
  task automatic send_word(input string tag, input logic [DW-1:0] d, input logic exp_par,
                           input logic inj, input logic hold, input logic [DW-1:0] nxt);
    logic [FB-1:0] bits;
    logic [3:0]    exp;
    bits = {1'b1, exp_par, d, 1'b0};
    check({tag, "_ready"}, in_ready, 1);
    in_data  = d;
    in_valid = 1'b1;
`ifdef PARITY_ERR_INJ_EN
    inj_err = inj;
`else
    if (inj) $display("note: %s inj ignored, feature not built", tag);
`endif
    @(posedge clk);
    #1;
    in_valid = hold;
    in_data  = nxt;
`ifdef PARITY_ERR_INJ_EN
    inj_err = 1'b0;
`endif
    for (int c = 0; c < FB * BD; c++) begin
      @(negedge clk);
      exp = {bits[c / BD], (c == FB * BD - 1), 1'b1, 1'b0};
      check($sformatf("%s_c%0d", tag, c + 1), {tx, done, busy, in_ready}, exp);
    end
    @(negedge clk);
    check({tag, "_idle"}, {tx, done, busy, in_ready}, 4'b1001);
  endtask

  // Same for the DATA_W=3, BAUD_DIV=1 instance: 6-cycle frame.
  task automatic send3(input logic [2:0] d, input logic exp_par, input logic inj);
    logic [5:0] bits;
    logic [3:0] exp;
    bits = {1'b1, exp_par, d, 1'b0};
    check($sformatf("w3_%0d_ready", d), in_ready3, 1);
    in_data3  = d;
    in_valid3 = 1'b1;
`ifdef PARITY_ERR_INJ_EN
    inj_err3 = inj;
`else
    if (inj) $display("note: w3 inj ignored, feature not built");
`endif
    @(posedge clk);
    #1;
    in_valid3 = 1'b0;
`ifdef PARITY_ERR_INJ_EN
    inj_err3 = 1'b0;
`endif
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp = {bits[c], (c == 5), 1'b1, 1'b0};
      check($sformatf("w3_%0d_c%0d", d, c + 1), {tx3, done3, busy3, in_ready3}, exp);
    end
    @(negedge clk);
    check($sformatf("w3_%0d_idle", d), {tx3, done3, busy3, in_ready3}, 4'b1001);
  endtask

  initial begin
    logic [7:0]  par3;
    logic [FB-1:0] bits;
    logic [3:0]  exp;
    par3      = 8'b1001_0110;  // hand parity of values 7..0
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_data3  = '0;
    in_valid3 = 1'b0;
`ifdef PARITY_ERR_INJ_EN
    inj_err   = 1'b0;
    inj_err3  = 1'b0;
`endif

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rst_%0d", i), {tx, done, busy, in_ready}, 4'b1000);
      check($sformatf("rst3_%0d", i), {tx3, done3, busy3, in_ready3}, 4'b1000);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst", {tx, done, busy, in_ready}, 4'b1001);
    check("post_rst3", {tx3, done3, busy3, in_ready3}, 4'b1001);

    // Directed frames: 0xA5 (4 ones), 0x07 (3 ones), 0x00
    send_word("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 8'h5A);
    send_word("07", 8'h07, 1'b1, 1'b0, 1'b0, 8'hF8);
    send_word("00", 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF);

    // Back-to-back with in_valid held; in_data switches to 0xFF mid-frame
    send_word("b2b_01", 8'h01, 1'b1, 1'b0, 1'b1, 8'hFF);
    send_word("b2b_ff", 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00);

    // Reset in cycle 20 of a 0x5A frame (four ones, parity 0)
    bits     = {1'b1, 1'b0, 8'h5A, 1'b0};
    in_data  = 8'h5A;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      exp = {bits[c / BD], 1'b0, 1'b1, 1'b0};
      check($sformatf("abort_c%0d", c + 1), {tx, done, busy, in_ready}, exp);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst", {tx, done, busy, in_ready}, 4'b1000);
    check("abort_state", u_dut.state, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_release", {tx, done, busy, in_ready}, 4'b1001);
    send_word("after_abort", 8'h3C, 1'b0, 1'b0, 1'b0, 8'hC3);

`ifdef PARITY_ERR_INJ_EN
    send_word("inj_a5", 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00);
    send_word("noinj_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
`endif

    // DATA_W=3, BAUD_DIV=1: all 8 values
    for (int v = 0; v < 8; v++) begin
      send3(3'(v), par3[v], 1'b0);
    end
`ifdef PARITY_ERR_INJ_EN
    send3(3'd3, 1'b1, 1'b1);
    send3(3'd3, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
